// File: rtl/gx_fifo_producer.sv
// gx_fifo_producer: packs 8/16/32-bit CPU stores into big-endian 32-bit words
// and buffers them in a first-word-fall-through FIFO for the Command Processor.
// Reports fill level, hi/lo watermarks and a sticky overflow flag.
module gx_fifo_producer #(
    parameter int unsigned DEPTH_LOG2   = 5,
    parameter int unsigned HI_WATERMARK = 24,
    parameter int unsigned LO_WATERMARK = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [1:0]            wr_size,
    input  logic [31:0]           wr_data,
    output logic                  wr_ready,
    input  logic                  flush,
    input  logic                  GXFIFORead,
    output logic                  GXFIFOValid,
    output logic [31:0]           GXFIFOData,
    output logic [DEPTH_LOG2:0]   fifo_count,
    output logic                  hi_wm,
    output logic                  lo_wm,
    output logic                  overflow,
    input  logic                  overflow_clr
);

    localparam int unsigned        DEPTH   = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] DEPTH_C = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [DEPTH_LOG2:0] HI_WM_C = HI_WATERMARK[DEPTH_LOG2:0];
    localparam logic [DEPTH_LOG2:0] LO_WM_C = LO_WATERMARK[DEPTH_LOG2:0];

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2,
        SZ_RSVD = 2'd3
    } store_size_e;

    // Storage and state
    logic [31:0]           r_mem [DEPTH];
    logic [DEPTH_LOG2-1:0] r_wr_ptr;
    logic [DEPTH_LOG2-1:0] r_rd_ptr;
    logic [DEPTH_LOG2:0]   r_count;
    logic [31:0]           r_pack_buf;
    logic [1:0]            r_pack_bytes;
    logic                  r_overflow;

    // Combinational helpers
    store_size_e           w_size;
    logic                  w_store_ok;
    logic                  w_drop;
    logic                  w_flush_ok;
    logic [2:0]            w_n;
    logic [31:0]           w_store_lj;
    logic [63:0]           w_merged;
    logic [2:0]            w_total;
    logic                  w_push;
    logic [31:0]           w_push_data;
    logic                  w_pop;
    logic [31:0]           w_next_buf;
    logic [1:0]            w_next_bytes;

    assign w_size      = store_size_e'(wr_size);
    assign wr_ready    = (r_count != DEPTH_C);
    assign GXFIFOValid = (r_count != '0);
    assign GXFIFOData  = GXFIFOValid ? r_mem[r_rd_ptr] : 32'h0;
    assign fifo_count  = r_count;
    assign hi_wm       = (r_count >= HI_WM_C);
    assign lo_wm       = (r_count <= LO_WM_C);
    assign overflow    = r_overflow;

    assign w_store_ok = wr_en && wr_ready && (w_size != SZ_RSVD);
    assign w_drop     = wr_en && !wr_ready && (w_size != SZ_RSVD);
    assign w_flush_ok = flush && !wr_en && wr_ready && (r_pack_bytes != 2'd0);
    assign w_pop      = GXFIFORead && GXFIFOValid;

    // Left-justify the store bytes and merge them behind the bytes already packed
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        w_n        = 3'd0;
        w_store_lj = 32'h0;
        case (w_size)
            SZ_BYTE: begin w_n = 3'd1; w_store_lj = {wr_data[7:0], 24'h0};  end
            SZ_HALF: begin w_n = 3'd2; w_store_lj = {wr_data[15:0], 16'h0}; end
            SZ_WORD: begin w_n = 3'd4; w_store_lj = wr_data;                end
            default: begin w_n = 3'd0; w_store_lj = 32'h0;                  end
        endcase
        // Bytes of r_pack_buf past r_pack_bytes are always zero, so OR-merging is safe.
        w_merged = {r_pack_buf, 32'h0} | ({w_store_lj, 32'h0} >> {r_pack_bytes, 3'b000});
        w_total  = {1'b0, r_pack_bytes} + w_n;
    end

    // Decide the push and the next packer state
    always_comb begin
        w_push       = 1'b0;
        w_push_data  = 32'h0;
        w_next_buf   = r_pack_buf;
        w_next_bytes = r_pack_bytes;
        if (w_store_ok) begin
            if (w_total >= 3'd4) begin
                w_push       = 1'b1;
                w_push_data  = w_merged[63:32];
                w_next_buf   = w_merged[31:0];
                w_next_bytes = 2'(w_total - 3'd4);
            end else begin
                w_next_buf   = w_merged[63:32];
                w_next_bytes = w_total[1:0];
            end
        end else if (w_flush_ok) begin
            w_push       = 1'b1;
            w_push_data  = r_pack_buf;
            w_next_buf   = 32'h0;
            w_next_bytes = 2'd0;
        end
    end

    // Word storage written on push
    // NOTE: the data array has no reset; validity is tracked by r_count, and leaving
    // it unreset lets it map onto RAM.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_push_data;
        end
    end

    // Pointers, count, packer and overflow flag
    // NOTE: sequential state uses non-blocking assignment so all registers update together.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_pack_buf   <= 32'h0;
            r_pack_bytes <= 2'd0;
            r_overflow   <= 1'b0;
        end else begin
            r_pack_buf   <= w_next_buf;
            r_pack_bytes <= w_next_bytes;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (!w_push && w_pop) begin
                r_count <= r_count - 1'b1;
            end
            // A drop in the same cycle as a clear wins.
            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (overflow_clr) begin
                r_overflow <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_gx_fifo_producer.sv
// tb_gx_fifo_producer: directed stimulus with hand-computed expected words.
module tb_gx_fifo_producer;

    logic        clk;
    logic        reset;
    logic        wr_en;
    logic [1:0]  wr_size;
    logic [31:0] wr_data;
    logic        wr_ready;
    logic        flush;
    logic        GXFIFORead;
    logic        GXFIFOValid;
    logic [31:0] GXFIFOData;
    logic [5:0]  fifo_count;
    logic        hi_wm;
    logic        lo_wm;
    logic        overflow;
    logic        overflow_clr;

    int n_cmp = 0;
    int n_err = 0;

    gx_fifo_producer #(
        .DEPTH_LOG2  (5),
        .HI_WATERMARK(24),
        .LO_WATERMARK(8)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .wr_en       (wr_en),
        .wr_size     (wr_size),
        .wr_data     (wr_data),
        .wr_ready    (wr_ready),
        .flush       (flush),
        .GXFIFORead  (GXFIFORead),
        .GXFIFOValid (GXFIFOValid),
        .GXFIFOData  (GXFIFOData),
        .fifo_count  (fifo_count),
        .hi_wm       (hi_wm),
        .lo_wm       (lo_wm),
        .overflow    (overflow),
        .overflow_clr(overflow_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic store(input logic [1:0] size, input logic [31:0] data);
        wr_en   = 1'b1;
        wr_size = size;
        wr_data = data;
        tick();
        wr_en   = 1'b0;
    endtask

    task automatic pop_chk(input string tag, input logic [31:0] exp);
        chk({tag, "_valid"}, 32'(GXFIFOValid), 32'd1);
        chk(tag, GXFIFOData, exp);
        GXFIFORead = 1'b1;
        tick();
        GXFIFORead = 1'b0;
    endtask

    task automatic do_flush();
        flush = 1'b1;
        tick();
        flush = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        reset        = 1'b1;
        wr_en        = 1'b0;
        wr_size      = 2'd0;
        wr_data      = 32'h0;
        flush        = 1'b0;
        GXFIFORead   = 1'b0;
        overflow_clr = 1'b0;
        tick();
        tick();
        reset = 1'b0;

        // Reset state
        chk("rst_valid", 32'(GXFIFOValid), 32'd0);
        chk("rst_data",  GXFIFOData,       32'h0);
        chk("rst_count", 32'(fifo_count),  32'd0);
        chk("rst_ready", 32'(wr_ready),    32'd1);
        chk("rst_hi",    32'(hi_wm),       32'd0);
        chk("rst_lo",    32'(lo_wm),       32'd1);
        chk("rst_ovf",   32'(overflow),    32'd0);

        // 1: eight word stores, head valid one cycle after the first
        for (int i = 0; i < 8; i++) begin
            store(2'd2, 32'h11223344 + 32'(i));
            if (i == 0) chk("t1_valid_first", 32'(GXFIFOValid), 32'd1);
        end
        chk("t1_count8", 32'(fifo_count), 32'd8);
        for (int i = 0; i < 8; i++) pop_chk("t1_pop", 32'h11223344 + 32'(i));
        chk("t1_count0", 32'(fifo_count), 32'd0);
        chk("t1_empty",  32'(GXFIFOValid), 32'd0);

        // 2: byte packing and leftover carry
        store(2'd0, 32'hAA);
        store(2'd0, 32'hBB);
        store(2'd0, 32'hCC);
        chk("t2_no_push", 32'(fifo_count), 32'd0);
        store(2'd0, 32'hDD);
        pop_chk("t2_bytes", 32'hAABBCCDD);
        store(2'd0, 32'hAA);
        store(2'd0, 32'hBB);
        store(2'd0, 32'hCC);
        store(2'd1, 32'h1234);
        pop_chk("t2_mixed", 32'hAABBCC12);
        store(2'd0, 32'h56);
        store(2'd0, 32'h78);
        store(2'd0, 32'h9A);
        pop_chk("t2_leftover", 32'h3456789A);

        // 3: word straddling a half, then flush of the remainder
        store(2'd1, 32'h1111);
        store(2'd2, 32'hCAFEBABE);
        pop_chk("t3_straddle", 32'h1111CAFE);
        do_flush();
        pop_chk("t3_flush", 32'hBABE0000);
        do_flush();
        chk("t3_flush_noop", 32'(fifo_count), 32'd0);
        // reserved size is ignored; flush alongside a store is ignored
        store(2'd0, 32'h01);
        store(2'd3, 32'hFFFFFFFF);
        flush = 1'b1;
        store(2'd0, 32'h02);
        flush = 1'b0;
        chk("t3_flush_with_wr", 32'(fifo_count), 32'd0);
        store(2'd0, 32'h03);
        store(2'd0, 32'h04);
        pop_chk("t3_rsvd", 32'h01020304);

        // 4: fill to full, watermark edges, overflow set/clear
        for (int i = 0; i < 32; i++) begin
            store(2'd2, 32'hA0000000 + 32'(i));
            if (i == 7)  chk("t4_lo_at8",  32'(lo_wm), 32'd1);
            if (i == 8)  chk("t4_lo_at9",  32'(lo_wm), 32'd0);
            if (i == 22) chk("t4_hi_at23", 32'(hi_wm), 32'd0);
            if (i == 23) chk("t4_hi_at24", 32'(hi_wm), 32'd1);
        end
        chk("t4_count_full", 32'(fifo_count), 32'd32);
        chk("t4_ready_full", 32'(wr_ready),   32'd0);
        chk("t4_hi_full",    32'(hi_wm),      32'd1);
        store(2'd2, 32'hDEADBEEF);
        chk("t4_ovf_set",    32'(overflow),   32'd1);
        chk("t4_count_kept", 32'(fifo_count), 32'd32);
        overflow_clr = 1'b1;
        store(2'd0, 32'h55);
        chk("t4_ovf_set_wins", 32'(overflow), 32'd1);
        tick();
        overflow_clr = 1'b0;
        chk("t4_ovf_clr", 32'(overflow), 32'd0);
        for (int i = 0; i < 32; i++) pop_chk("t4_pop", 32'hA0000000 + 32'(i));
        chk("t4_drained", 32'(fifo_count), 32'd0);

        // 5: steady push and pop at count 5, pointers wrap
        for (int i = 0; i < 5; i++) store(2'd2, 32'h50000000 + 32'(i));
        for (int c = 0; c < 40; c++) begin
            chk("t5_head", GXFIFOData, 32'h50000000 + 32'(c));
            wr_en      = 1'b1;
            wr_size    = 2'd2;
            wr_data    = 32'h50000000 + 32'(c + 5);
            GXFIFORead = 1'b1;
            tick();
        end
        wr_en      = 1'b0;
        GXFIFORead = 1'b0;
        chk("t5_count", 32'(fifo_count), 32'd5);
        for (int j = 0; j < 5; j++) pop_chk("t5_drain", 32'h50000000 + 32'(40 + j));

        // 6: reset mid-operation discards words and partial word
        for (int i = 0; i < 10; i++) store(2'd2, 32'h60000000 + 32'(i));
        store(2'd1, 32'hEEEE);
        chk("t6_count10", 32'(fifo_count), 32'd10);
        do_reset();
        chk("t6_valid", 32'(GXFIFOValid), 32'd0);
        chk("t6_count", 32'(fifo_count),  32'd0);
        chk("t6_data",  GXFIFOData,       32'h0);
        store(2'd0, 32'h01);
        store(2'd0, 32'h02);
        store(2'd0, 32'h03);
        store(2'd0, 32'h04);
        pop_chk("t6_fresh", 32'h01020304);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
